// File: rtl/tinker_pkg.sv
// ============================================================================
// Module   : tinker_pkg
// Brief    : Shared encoding constants and instruction layout for tinker_core.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tinker_pkg;

    localparam int XLEN      = 64;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;

    localparam int OP_LSB = 27;
    localparam int RD_LSB = 22;
    localparam int RS_LSB = 17;
    localparam int RT_LSB = 12;
    localparam int L_LSB  = 0;
    localparam int L_W    = 12;

    localparam logic [4:0] OP_AND    = 5'h00;
    localparam logic [4:0] OP_OR     = 5'h01;
    localparam logic [4:0] OP_XOR    = 5'h02;
    localparam logic [4:0] OP_NOT    = 5'h03;
    localparam logic [4:0] OP_SHFTR  = 5'h04;
    localparam logic [4:0] OP_SHFTRI = 5'h05;
    localparam logic [4:0] OP_SHFTL  = 5'h06;
    localparam logic [4:0] OP_SHFTLI = 5'h07;
    localparam logic [4:0] OP_MOVR   = 5'h11;
    localparam logic [4:0] OP_MOVL   = 5'h12;
    localparam logic [4:0] OP_ADD    = 5'h18;
    localparam logic [4:0] OP_ADDI   = 5'h19;
    localparam logic [4:0] OP_SUB    = 5'h1a;
    localparam logic [4:0] OP_SUBI   = 5'h1b;
    localparam logic [4:0] OP_MUL    = 5'h1c;
    localparam logic [4:0] OP_DIV    = 5'h1d;

    typedef struct packed {
        logic [4:0]           op;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [L_W-1:0]       L;
    } instr_t;

endpackage

`default_nettype wire

// File: rtl/tinker_alu.sv
// ============================================================================
// Module   : tinker_alu
// Brief    : Combinational Tinker execute unit; flags opcodes outside the subset.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tinker_alu #(
    parameter int XLEN = tinker_pkg::XLEN
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic [XLEN-1:0] rd_val,
    input  logic [11:0]     L,
    output logic [XLEN-1:0] result,
    output logic            legal
);
    import tinker_pkg::*;

    logic [XLEN-1:0] l_ext;
    assign l_ext = {{(XLEN-12){1'b0}}, L};

    always_comb begin
        result = '0;
        legal  = 1'b1;
        case (op)
            OP_AND:    result = rs_val & rt_val;
            OP_OR:     result = rs_val | rt_val;
            OP_XOR:    result = rs_val ^ rt_val;
            OP_NOT:    result = ~rs_val;
            OP_SHFTR:  result = rd_val >> rt_val[5:0];
            OP_SHFTRI: result = rd_val >> L[5:0];
            OP_SHFTL:  result = rd_val << rt_val[5:0];
            OP_SHFTLI: result = rd_val << L[5:0];
            OP_MOVR:   result = rs_val;
            // Immediate move only replaces the low 12 bits.
            OP_MOVL:   result = {rd_val[XLEN-1:12], L};
            OP_ADD:    result = rs_val + rt_val;
            OP_ADDI:   result = rd_val + l_ext;
            OP_SUB:    result = rs_val - rt_val;
            OP_SUBI:   result = rd_val - l_ext;
            OP_MUL:    result = rs_val * rt_val;
            OP_DIV:    result = (rt_val == '0) ? '0 : rs_val / rt_val;
            default: begin
                result = '0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tinker_core.sv
// ============================================================================
// Module   : tinker_core
// Brief    : Single-cycle Tinker execute core with 32x64 register file.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tinker_core #(
    parameter int              NUM_REGS = 32,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] SP_RESET = 64'h0000_0000_0008_0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [31:0]     instruction,
    output logic [XLEN-1:0] result
);
    import tinker_pkg::*;

    instr_t          ins;
    logic            legal;
    logic [XLEN-1:0] regs [NUM_REGS];

    assign ins = instruction;

    tinker_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .op     (ins.op),
        .rs_val (regs[ins.rs]),
        .rt_val (regs[ins.rt]),
        .rd_val (regs[ins.rd]),
        .L      (ins.L),
        .result (result),
        .legal  (legal)
    );

    // Top register is the stack pointer and comes out of reset at SP_RESET.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= (i == NUM_REGS - 1) ? SP_RESET : '0;
            end
        end else if (instr_valid && legal) begin
            regs[ins.rd] <= result;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tinker_core.sv
// ============================================================================
// Module   : tb_tinker_core
// Brief    : Directed self-checking bench for tinker_core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tinker_core;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    tinker_core dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [11:0] l);
        return {op, rd, rs, rt, l};
    endfunction

    task automatic check(input string tag, input logic [63:0] exp);
        checks++;
        assert (result === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, result, exp);
        end
    endtask

    // Apply one instruction, check the combinational result, then clock it.
    task automatic step(input logic v, input logic [31:0] ins, input string tag,
                        input logic [63:0] exp);
        instr_valid = v;
        instruction = ins;
        #1;
        check(tag, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instruction = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        step(1'b0, enc(5'h18, 5'd1, 5'd2, 5'd3, 12'd0), "add_after_reset", 64'd0);
        step(1'b0, enc(5'h11, 5'd7, 5'd31, 5'd0, 12'd0), "sp_reset", 64'h80000);

        step(1'b1, enc(5'h12, 5'd2, 5'd0, 5'd0, 12'd5), "movl_r2", 64'd5);
        step(1'b1, enc(5'h12, 5'd3, 5'd0, 5'd0, 12'd7), "movl_r3", 64'd7);
        step(1'b1, enc(5'h18, 5'd1, 5'd2, 5'd3, 12'd0), "add_r1", 64'd12);
        step(1'b0, enc(5'h11, 5'd4, 5'd1, 5'd0, 12'd0), "r1_is_12", 64'd12);

        step(1'b1, enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd255), "addi_1", 64'h10B);
        step(1'b0, enc(5'h11, 5'd4, 5'd1, 5'd0, 12'd0), "movr_r1_10b", 64'h10B);
        step(1'b1, enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd255), "addi_2", 64'h20A);
        step(1'b1, enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd255), "addi_3", 64'h309);
        step(1'b0, enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd255), "addi_novalid", 64'h408);
        step(1'b0, enc(5'h11, 5'd4, 5'd1, 5'd0, 12'd0), "r1_held", 64'h309);

        step(1'b1, enc(5'h11, 5'd4, 5'd1, 5'd0, 12'd0), "movr_r4", 64'h309);
        step(1'b0, enc(5'h11, 5'd8, 5'd4, 5'd0, 12'd0), "r4_written", 64'h309);

        step(1'b1, enc(5'h1a, 5'd5, 5'd2, 5'd3, 12'd0), "sub_wrap", 64'hFFFF_FFFF_FFFF_FFFE);
        step(1'b1, enc(5'h12, 5'd5, 5'd0, 5'd0, 12'h123), "movl_keep_hi", 64'hFFFF_FFFF_FFFF_F123);
        step(1'b1, enc(5'h1d, 5'd6, 5'd3, 5'd0, 12'd0), "div_by_zero", 64'd0);
        step(1'b1, enc(5'h1d, 5'd6, 5'd1, 5'd2, 12'd0), "div", 64'h9B);
        step(1'b0, enc(5'h1b, 5'd6, 5'd0, 5'd0, 12'h9C), "subi_wrap", 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b1, enc(5'h1c, 5'd9, 5'd2, 5'd3, 12'd0), "mul", 64'd35);
        step(1'b1, enc(5'h07, 5'd3, 5'd0, 5'd0, 12'd4), "shftli", 64'h70);
        step(1'b0, enc(5'h11, 5'd10, 5'd3, 5'd0, 12'd0), "r3_shifted", 64'h70);
        step(1'b1, enc(5'h04, 5'd3, 5'd0, 5'd2, 12'd0), "shftr", 64'd3);
        step(1'b0, enc(5'h06, 5'd3, 5'd0, 5'd2, 12'd0), "shftl", 64'h60);
        step(1'b0, enc(5'h00, 5'd11, 5'd2, 5'd3, 12'd0), "and", 64'd1);
        step(1'b0, enc(5'h01, 5'd11, 5'd2, 5'd3, 12'd0), "or", 64'd7);
        step(1'b0, enc(5'h02, 5'd11, 5'd2, 5'd3, 12'd0), "xor", 64'd6);
        step(1'b0, enc(5'h03, 5'd11, 5'd2, 5'd0, 12'd0), "not", 64'hFFFF_FFFF_FFFF_FFFA);
        step(1'b0, enc(5'h05, 5'd5, 5'd0, 5'd0, 12'd4), "shftri", 64'h0FFF_FFFF_FFFF_FF12);
        step(1'b0, enc(5'h07, 5'd2, 5'd0, 5'd0, 12'd63), "shftli_63", 64'h8000_0000_0000_0000);

        step(1'b1, enc(5'h1f, 5'd1, 5'd2, 5'd3, 12'd0), "illegal_op", 64'd0);
        step(1'b0, enc(5'h11, 5'd7, 5'd1, 5'd0, 12'd0), "illegal_no_write", 64'h309);

        reset       = 1'b1;
        instr_valid = 1'b1;
        instruction = enc(5'h19, 5'd1, 5'd0, 5'd0, 12'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, enc(5'h11, 5'd7, 5'd1, 5'd0, 12'd0), "r1_cleared", 64'd0);
        step(1'b1, enc(5'h11, 5'd7, 5'd31, 5'd0, 12'd0), "mov_r7_sp", 64'h80000);
        step(1'b0, enc(5'h11, 5'd8, 5'd2, 5'd0, 12'd0), "r2_cleared", 64'd0);
        step(1'b0, enc(5'h11, 5'd8, 5'd7, 5'd0, 12'd0), "r7_written", 64'h80000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
